// File: rtl/ex_div_pkg.sv
// rtl/ex_div_pkg.sv - ex_div shared op encodings, FSM states and constants
package ex_div_pkg;

  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    DIVOP_DIV  = 2'b00,
    DIVOP_DIVU = 2'b01,
    DIVOP_REM  = 2'b10,
    DIVOP_REMU = 2'b11
  } divop_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic n);
    return n ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/ex_div_if.sv
// rtl/ex_div_if.sv - ID/EX to divider handshake and result bundle
interface ex_div_if;
  logic        id_ex_reg_valid_i;
  logic [1:0]  id_ex_reg_divop_i;
  logic [31:0] id_ex_reg_op_a_i;
  logic [31:0] id_ex_reg_op_b_i;
  logic        flush_i;
  logic        ex_div_busy_o;
  logic        ex_div_valid_o;
  logic [31:0] ex_div_result_o;

  modport master (
    output id_ex_reg_valid_i, id_ex_reg_divop_i, id_ex_reg_op_a_i, id_ex_reg_op_b_i, flush_i,
    input  ex_div_busy_o, ex_div_valid_o, ex_div_result_o
  );

  modport slave (
    input  id_ex_reg_valid_i, id_ex_reg_divop_i, id_ex_reg_op_a_i, id_ex_reg_op_b_i, flush_i,
    output ex_div_busy_o, ex_div_valid_o, ex_div_result_o
  );
endinterface

// File: rtl/ex_div.sv
// rtl/ex_div.sv - 32-cycle restoring radix-2 signed/unsigned divider for the EX stage
// EX_DIV_FAST_PATH_EN: divide-by-zero and signed overflow skip straight to DONE.
module ex_div
  import ex_div_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave bus
);

  state_e      state_q;
  logic [5:0]  cnt_q;
  logic        is_rem_q;
  logic        neg_quot_q;
  logic        neg_rem_q;
  logic [31:0] quot_q;
  logic [31:0] rem_q;
  logic [31:0] divisor_q;
  logic [31:0] result_q;
  logic        valid_q;

  logic        op_signed;
  logic        op_rem;
  logic        a_neg;
  logic        b_neg;
  logic        b_zero;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        start;
  logic        last_step;

  assign op_signed = ~bus.id_ex_reg_divop_i[0];
  assign op_rem    = bus.id_ex_reg_divop_i[1];
  assign a_neg     = op_signed & bus.id_ex_reg_op_a_i[31];
  assign b_neg     = op_signed & bus.id_ex_reg_op_b_i[31];
  assign b_zero    = (bus.id_ex_reg_op_b_i == 32'd0);
  assign abs_a     = neg_if(bus.id_ex_reg_op_a_i, a_neg);
  assign abs_b     = neg_if(bus.id_ex_reg_op_b_i, b_neg);
  assign start     = (state_q == ST_IDLE) & bus.id_ex_reg_valid_i & ~bus.flush_i;
  assign last_step = (cnt_q == 6'(DIV_CYCLES - 1));

  // A zero divisor makes every trial subtraction succeed, so the plain datapath
  // already yields an all-ones quotient and the dividend as remainder.
  logic [32:0] rem_shift;
  logic [32:0] diff;
  logic [31:0] quot_nx;
  logic [31:0] rem_nx;
  logic [31:0] res_fin;

  always_comb begin
    rem_shift = {rem_q, quot_q[31]};
    diff      = rem_shift - {1'b0, divisor_q};
    if (!diff[32]) begin
      rem_nx  = diff[31:0];
      quot_nx = {quot_q[30:0], 1'b1};
    end else begin
      rem_nx  = rem_shift[31:0];
      quot_nx = {quot_q[30:0], 1'b0};
    end
    res_fin = is_rem_q ? neg_if(rem_nx, neg_rem_q) : neg_if(quot_nx, neg_quot_q);
  end

  logic        special_hit;
  logic [31:0] special_res;

`ifdef EX_DIV_FAST_PATH_EN
  logic overflow;
  assign overflow    = op_signed & (bus.id_ex_reg_op_a_i == 32'h8000_0000) &
                       (bus.id_ex_reg_op_b_i == 32'hFFFF_FFFF);
  assign special_hit = b_zero | overflow;
  assign special_res = b_zero ? (op_rem ? bus.id_ex_reg_op_a_i : 32'hFFFF_FFFF)
                              : (op_rem ? 32'd0 : 32'h8000_0000);
`else
  assign special_hit = 1'b0;
  assign special_res = 32'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 6'd0;
      is_rem_q   <= 1'b0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      quot_q     <= 32'd0;
      rem_q      <= 32'd0;
      divisor_q  <= 32'd0;
      result_q   <= 32'd0;
      valid_q    <= 1'b0;
    end else if (bus.flush_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          valid_q <= 1'b0;
          if (start) begin
            if (special_hit) begin
              result_q <= special_res;
              valid_q  <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              is_rem_q   <= op_rem;
              neg_quot_q <= (a_neg ^ b_neg) & ~b_zero;
              neg_rem_q  <= a_neg;
              quot_q     <= abs_a;
              rem_q      <= 32'd0;
              divisor_q  <= abs_b;
              cnt_q      <= 6'd0;
              state_q    <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          quot_q <= quot_nx;
          rem_q  <= rem_nx;
          cnt_q  <= cnt_q + 6'd1;
          if (last_step) begin
            result_q <= res_fin;
            valid_q  <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // busy is combinational so a flush or reset releases the stall in the same cycle.
  assign bus.ex_div_busy_o   = ~rst & ~bus.flush_i & (start | (state_q == ST_CALC));
  assign bus.ex_div_valid_o  = valid_q & ~bus.flush_i;
  assign bus.ex_div_result_o = result_q;

endmodule
